// File: rtl/tile_sram_arbiter.sv
// tile_sram_arbiter: round-robin owner of one single-port Tile SRAM.
// A Core requests, is granted for a burst of beats that ends on core_last
// or after MAX_HOLD beats, and then yields to the next Core after a one-cycle
// bubble. Read data returns with a registered one-cycle valid pulse.
//
// Handshake: a Core raises core_req to ask for the port; once core_gnt is
// high, every cycle with core_req high is one beat issued to the SRAM, and a
// cycle with core_req low is an idle cycle that keeps the grant. The grant
// ends only on a beat with core_last high or on the MAX_HOLD-th beat.
// core_rvalid marks the cycle in which core_rdata holds the data of a read
// beat issued one cycle earlier.
module tile_sram_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_HOLD  = 16
) (
  input  logic                        clk,
  input  logic                        RSTn,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES-1:0]        core_last,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        sram_en,
  output logic                        sram_we,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_wdata,
  input  logic [DATA_W-1:0]           sram_rdata,
  output logic                        dbg_state_o
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CORES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     rd_owner_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_CORES-1:0] gnt_q;
  logic                 rd_pend_q;

  logic                 own_req;
  logic                 own_we;
  logic                 own_last;
  logic                 beat;
  logic                 release_beat;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;

  // Select the owner's request, controls, address and data slices.
  always_comb begin
    own_req    = 1'b0;
    own_we     = 1'b0;
    own_last   = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_req    = core_req[i];
        own_we     = core_we[i];
        own_last   = core_last[i];
        sram_addr  = core_addr[i*ADDR_W +: ADDR_W];
        sram_wdata = core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin pick: first requester at ptr, ptr+1, ... wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    for (int k = 0; k < NUM_CORES; k++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!pick_vld && core_req[i] &&
            ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + NUM_CORES))) begin
          pick_vld = 1'b1;
          pick_idx = IDX_W'(i);
        end
      end
    end
  end

  // A beat is the owner presenting a request while the grant is held.
  always_comb begin
    beat         = (state_q == BUSY) && own_req;
    release_beat = beat && (own_last || (cnt_q == HOLD_LAST));
    sram_en      = beat;
    sram_we      = beat && own_we;
    core_rdata   = sram_rdata;
    core_gnt     = gnt_q;
    dbg_state_o  = (state_q == BUSY);
  end

  // Decode the pending read into a one-hot valid for the Core that issued it.
  always_comb begin
    core_rvalid = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (rd_pend_q && (rd_owner_q == IDX_W'(i))) core_rvalid[i] = 1'b1;
    end
  end

  // Grant FSM with registered grant, beat counter and read-return tracking.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      rd_pend_q <= beat && !own_we;
      if (beat && !own_we) rd_owner_q <= owner_q;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= BUSY;
            owner_q <= pick_idx;
            gnt_q   <= NUM_CORES'(1) << pick_idx;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (release_beat) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
          end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
